// File: rtl/jk_excite_driver.sv
// Drives a JK register bank toward a target word through the bank's excitation
// inputs, verifies the result from Q feedback and re-drives a limited number of times.
module jk_excite_driver #(
  parameter int W         = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tgt_valid,
  input  logic [W-1:0] tgt_data,
  output logic         tgt_ready,
  output logic [W-1:0] jk_j,
  output logic [W-1:0] jk_k,
  input  logic [W-1:0] q_fb,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] err_mask
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  tgt_q, tgt_d;
  logic [W-1:0]  j_q, j_d;
  logic [W-1:0]  k_q, k_d;
  logic [W-1:0]  mask_q, mask_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      mask_q  <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      mask_q  <= mask_d;
      retry_q <= retry_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // In this bank J alone clears and K alone sets; the toggle code is never produced.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    mask_d  = mask_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_d   = tgt_data;
          mask_d  = '0;
          retry_d = '0;
          j_d     = q_fb & ~tgt_data;
          k_d     = ~q_fb & tgt_data;
          state_d = DRIVE;
        end
      end
      DRIVE:  state_d = SETTLE;
      SETTLE: state_d = CHECK;
      CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          mask_d  = q_fb ^ tgt_q;
          j_d     = q_fb & ~tgt_q;
          k_d     = ~q_fb & tgt_q;
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          mask_d  = q_fb ^ tgt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign jk_j      = j_q;
  assign jk_k      = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = mask_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Bench for jk_excite_driver: a behavioural JK bank with optional stuck-at-0 bits
// closes the loop, and each transfer's outcome is predicted from target and stuck mask.
module tb_jk_excite_driver;

  localparam int W         = 8;
  localparam int MAX_RETRY = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         tgt_valid;
  logic [W-1:0] tgt_data;
  logic         tgt_ready;
  logic [W-1:0] jk_j, jk_k, q_fb, err_mask;
  logic         busy, done, err;

  logic [W-1:0] bank;
  logic [W-1:0] stuck;
  logic         load;
  logic [W-1:0] load_val;

  int checks = 0;
  int errors = 0;

  jk_excite_driver #(.W(W), .MAX_RETRY(MAX_RETRY)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt_valid (tgt_valid),
    .tgt_data  (tgt_data),
    .tgt_ready (tgt_ready),
    .jk_j      (jk_j),
    .jk_k      (jk_k),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_mask  (err_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] cell_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                             input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b1;
        2'b10:   r[i] = 1'b0;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (load) bank <= load_val & ~stuck;
    else      bank <= cell_next(bank, jk_j, jk_k) & ~stuck;
  end
  assign q_fb = bank;

  task automatic check8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [W-1:0] v, input logic [W-1:0] s);
    @(negedge clk);
    stuck    = s;
    load     = 1'b1;
    load_val = v;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Called one step after the accepting edge; returns one step after the done/err edge.
  task automatic finish_xfer(input logic [W-1:0] t, input logic [W-1:0] pre);
    logic [W-1:0] msk;
    logic [W-1:0] any_drv;
    logic         tog, both;
    int           n, exp_n;
    msk = t & stuck;
    exp_n = (msk == '0) ? 3 : 3 * (MAX_RETRY + 1);
    check8("drive_j", jk_j, pre & ~t);
    check8("drive_k", jk_k, ~pre & t);
    check1("busy_drive", busy, 1'b1);
    check1("ready_drive", tgt_ready, 1'b0);
    any_drv = jk_j | jk_k;
    tog = |(jk_j & jk_k);
    both = 1'b0;
    n = 0;
    while (n < 40 && !(done || err)) begin
      @(posedge clk);
      #1;
      n++;
      any_drv |= jk_j | jk_k;
      tog  |= |(jk_j & jk_k);
      both |= done & err;
    end
    check8("latency", 8'(n), 8'(exp_n));
    check1("done", done, msk == '0);
    check1("err", err, msk != '0);
    check1("done_and_err", both, 1'b0);
    check1("toggle_code", tog, 1'b0);
    check8("err_mask", err_mask, msk);
    check8("q_final", q_fb, t & ~stuck);
    check1("ready_end", tgt_ready, 1'b1);
    check1("busy_end", busy, 1'b0);
    if (pre == t) check8("noop_drive", any_drv, '0);
  endtask

  task automatic xfer(input logic [W-1:0] t);
    logic [W-1:0] pre;
    @(negedge clk);
    pre       = bank;
    tgt_valid = 1'b1;
    tgt_data  = t;
    check1("ready_idle", tgt_ready, 1'b1);
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    tgt_data  = W'($urandom);
    finish_xfer(t, pre);
  endtask

  initial begin
    logic [W-1:0] pre, t, s;
    logic         seen;
    rst = 1'b1; tgt_valid = 1'b0; tgt_data = '0;
    load = 1'b1; load_val = '0; stuck = '0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_ready", tgt_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_err", err, 1'b0);
    check8("rst_j", jk_j, '0);
    check8("rst_k", jk_k, '0);
    check8("rst_mask", err_mask, '0);
    rst = 1'b0; load = 1'b0;

    // Basic and mixed transfers
    preload(8'h00, 8'h00);
    xfer(8'hA5);
    preload(8'hF0, 8'h00);
    xfer(8'h3C);

    // Stuck bit 0: retries exhausted, mask held while idle
    preload(8'h00, 8'h01);
    xfer(8'h01);
    repeat (3) @(posedge clk);
    #1;
    check8("mask_hold", err_mask, 8'h01);
    check1("err_single_pulse", err, 1'b0);
    preload(8'h00, 8'h00);

    // Back-to-back with tgt_valid held high
    @(negedge clk);
    pre = bank;
    tgt_valid = 1'b1;
    tgt_data  = 8'h11;
    @(posedge clk);
    #1;
    finish_xfer(8'h11, pre);
    pre = bank;
    tgt_data = 8'h22;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    finish_xfer(8'h22, pre);

    // Reset while in SETTLE
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_data  = 8'hC3;
    @(posedge clk);
    #1 tgt_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check1("mid_rst_ready", tgt_ready, 1'b1);
    check1("mid_rst_busy", busy, 1'b0);
    check8("mid_rst_j", jk_j, '0);
    check8("mid_rst_k", jk_k, '0);
    check8("mid_rst_mask", err_mask, '0);
    seen = 1'b0;
    repeat (5) begin
      seen |= done | err;
      @(posedge clk);
      #1;
    end
    check1("mid_rst_no_pulse", seen, 1'b0);

    // No-op target
    preload(8'h5A, 8'h00);
    xfer(8'h5A);

    // Reset beats tgt_valid on the same edge
    @(negedge clk);
    rst = 1'b1;
    tgt_valid = 1'b1;
    tgt_data = 8'hFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tgt_valid = 1'b0;
    check1("rst_prio_busy", busy, 1'b0);

    // Randomized transfers, occasionally with a stuck bit
    for (int it = 0; it < 24; it++) begin
      t = W'($urandom);
      s = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
      preload(W'($urandom), s);
      xfer(t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_excite_driver.md
JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 SHALL have parameter W, default 8, which sets the width of the driven JK register bank.
REQ-002 SHALL have parameter MAX_RETRY, default 3, which sets the number of re-drive attempts after a failed check.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port tgt_valid, input, 1 bit: target word offered.
REQ-006 SHALL have port tgt_data, input, W bits: target value for the JK bank.
REQ-007 SHALL have port tgt_ready, output, 1 bit: block accepts a target this cycle.
REQ-008 SHALL have port jk_j, output, W bits: per-bit J drive to the JK bank.
REQ-009 SHALL have port jk_k, output, W bits: per-bit K drive to the JK bank.
REQ-010 SHALL have port q_fb, input, W bits: Q feedback from the JK bank, which is clocked by clk.
REQ-011 SHALL have port busy, output, 1 bit: transfer in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on a successful transfer.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse when retries are exhausted.
REQ-014 SHALL have port err_mask, output, W bits: the q_fb ^ target bits from the last failed check.

Function
REQ-015 SHALL use the following JK cell excitation table for every bit:
- J=0, K=0: hold.
- J=0, K=1: Q becomes 1.
- J=1, K=0: Q becomes 0.
- J=1, K=1: toggle.
REQ-016 SHALL implement FSM states IDLE, DRIVE, SETTLE and CHECK.
REQ-017 SHALL in IDLE drive tgt_ready=1, busy=0 and jk_j=jk_k=0.
REQ-018 SHALL on the edge where tgt_valid && tgt_ready (E0):
- latch tgt_data into an internal target register;
- clear err_mask;
- clear the retry counter;
- go to DRIVE.
REQ-019 SHALL at E0 register the excitation for each bit i:
- q_fb[i]==t[i]: J=0, K=0.
- t[i]=1, q_fb[i]=0: J=0, K=1.
- t[i]=0, q_fb[i]=1: J=1, K=0.
- The toggle code (J=1, K=1) is never issued.
REQ-020 SHALL hold jk_j/jk_k for exactly one cycle (DRIVE), return them to 0 at the next edge E1, and go to SETTLE.
REQ-021 SHALL go from SETTLE to CHECK at edge E2, then at edge E3 compare q_fb against the latched target.
REQ-022 SHALL on a match at E3:
- pulse done=1 for the cycle after E3;
- go to IDLE.
Accept-to-done latency is 3 cycles with no retries.
REQ-023 SHALL on a mismatch at E3 with retry count < MAX_RETRY:
- increment the count;
- load err_mask;
- re-register the excitation from the current q_fb;
- go to DRIVE.
Each retry adds 3 cycles.
REQ-024 SHALL on a mismatch at E3 with retry count == MAX_RETRY:
- pulse err=1 for one cycle;
- load err_mask;
- go to IDLE.
REQ-025 SHALL hold tgt_ready=0 and busy=1 in DRIVE, SETTLE and CHECK; tgt_valid is ignored there and tgt_data changes have no effect.
REQ-026 SHALL allow a new accept in the same cycle that done or err is high (back-to-back transfers).
REQ-027 SHALL never assert done and err in the same cycle.
REQ-028 SHALL treat a target equal to q_fb at E0 as a normal transfer: all-zero drive, done 3 cycles later.
REQ-029 SHALL keep err_mask stable from IDLE until the next accept.

Reset
REQ-030 SHALL while rst=1 at an edge set:
- state to IDLE;
- jk_j=0 and jk_k=0;
- done=0, err=0, busy=0;
- err_mask=0;
- retry count to 0;
- the target register to 0.
REQ-031 SHALL, when rst is asserted mid-transfer, abort the transfer with no done or err pulse, and have tgt_ready=1 in the first cycle after reset deasserts.
REQ-032 SHALL take reset priority over tgt_valid on the same edge.

Verification (W=8, MAX_RETRY=3, bench uses a model JK bank per REQ-015)
REQ-033 SHALL cover a basic transfer: bank at 0x00, target 0xA5 → jk_k=0xA5 and jk_j=0x00 for one cycle, q_fb=0xA5, done at +3 cycles, err_mask=0x00.
REQ-034 SHALL cover a mixed transfer: bank at 0xF0, target 0x3C → jk_j=0xC0 and jk_k=0x0C, then done.
REQ-035 SHALL cover a stuck bit: bank bit 0 forced to 0, target 0x01 → 3 re-drives, err pulse at +12 cycles, err_mask=0x01, no done.
REQ-036 SHALL cover back-to-back transfers: tgt_valid held high with 0x11 then 0x22 → second accept in the done cycle of the first, q_fb=0x22 at the end.
REQ-037 SHALL cover reset during SETTLE: rst for 1 cycle → outputs at reset values, no done or err, tgt_ready=1 on the next cycle.
REQ-038 SHALL cover a no-op target: target equal to the current Q (0x5A) → jk_j=jk_k=0 throughout, done at +3 cycles.
